// File: rtl/tb_run_monitor_if.sv
// AXI write address/data channel bundle observed by the run monitor.
// The monitor only snoops, so every signal is an input on the slave side.
interface tb_run_monitor_if #(
  parameter int AXI_AW = 40,
  parameter int AXI_DW = 128
) ();
  logic                  awvalid;
  logic                  awready;
  logic [AXI_AW-1:0]     awaddr;
  logic [3:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [AXI_DW/8-1:0]   wstrb;
  logic [AXI_DW-1:0]     wdata;

  modport master (
    output awvalid, awready, awaddr, awlen,
    output wvalid, wready, wlast, wstrb, wdata
  );

  modport slave (
    input awvalid, awready, awaddr, awlen,
    input wvalid, wready, wlast, wstrb, wdata
  );
endinterface

// File: rtl/tb_run_monitor.sv
// Run-status monitor: pass/fail magic detection, retire watchdog, cycle and
// retire counters, and an AXI console-write snooper feeding a show-ahead FIFO.
module tb_run_monitor #(
  parameter int          NUM_RETIRE = 2,
  parameter int          NUM_WB     = 2,
  parameter int          WB_W       = 64,
  parameter int          AXI_AW     = 40,
  parameter int          AXI_DW     = 128,
  parameter int          CHK_CYC    = 50000,
  parameter int          CNT_W      = 32,
  parameter logic [63:0] PASS_VAL   = 64'h444333222,
  parameter logic [63:0] FAIL_VAL   = 64'h2382348720,
  parameter logic [31:0] CON_ADDR   = 32'h90000000,
  parameter int          CON_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RETIRE-1:0]  retire_vld,
  input  logic [NUM_WB-1:0]      wb_vld,
  input  logic [NUM_WB*WB_W-1:0] wb_data,
  tb_run_monitor_if.slave        axi,
  input  logic                   con_rdy,
  output logic                   con_vld,
  output logic [7:0]             con_char,
  output logic                   con_ovf,
  output logic                   done,
  output logic                   st_pass,
  output logic                   st_fail,
  output logic                   st_timeout,
  output logic [CNT_W-1:0]       cyc_cnt,
  output logic [63:0]            retire_total
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [WB_W-1:0] PASS_W   = WB_W'(PASS_VAL);
  localparam logic [WB_W-1:0] FAIL_W   = WB_W'(FAIL_VAL);
  localparam int              WIN_W    = $clog2(CHK_CYC);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CHK_CYC - 1);
  localparam int              NLANE    = AXI_DW / 32;
  localparam int              NBYTE    = AXI_DW / 8;
  localparam int              PTR_W    = $clog2(CON_DEPTH);

  state_t            r_state, w_state_nxt;
  logic              w_pass_hit, w_fail_hit;
  logic [WIN_W-1:0]  r_win_cnt;
  logic              r_win_seen;
  logic              w_any_ret, w_win_end, w_timeout, w_count_en;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic [63:0]       r_retire_total;

  // ---------------- magic detection ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_pass_hit = 1'b0;
    w_fail_hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == FAIL_W) w_fail_hit = 1'b1;
      if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == PASS_W) w_pass_hit = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  assign w_any_ret = |retire_vld;
  assign w_win_end = (r_win_cnt == WIN_LAST);
  assign w_timeout = w_win_end && !r_win_seen && !w_any_ret;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_win_cnt  <= '0;
      r_win_seen <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_win_end) begin
        r_win_cnt  <= '0;
        r_win_seen <= 1'b0;
      end else begin
        r_win_cnt  <= r_win_cnt + 1'b1;
        r_win_seen <= r_win_seen | w_any_ret;
      end
    end
  end

  // ---------------- run state machine ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = (r_state != S_RUN);
    st_pass     = (r_state == S_PASS);
    st_fail     = (r_state == S_FAIL);
    st_timeout  = (r_state == S_TIMEOUT);
    if (r_state == S_RUN) begin
      if (w_fail_hit)      w_state_nxt = S_FAIL;
      else if (w_pass_hit) w_state_nxt = S_PASS;
      else if (w_timeout)  w_state_nxt = S_TIMEOUT;
    end
  end

  // Counters stop on the very edge that leaves RUN.
  assign w_count_en = (r_state == S_RUN) && (w_state_nxt == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt      <= '0;
      r_retire_total <= '0;
    end else if (w_count_en) begin
      r_cyc_cnt      <= r_cyc_cnt + 1'b1;
      r_retire_total <= r_retire_total + 64'($countones(retire_vld));
    end
  end

  assign cyc_cnt      = r_cyc_cnt;
  assign retire_total = r_retire_total;

  // ---------------- console snoop ----------------
  logic       r_pending;
  logic       w_aw_hs, w_w_hs, w_aw_match, w_snoop, w_chr_vld, w_push;
  logic [7:0] w_chr;

  assign w_aw_hs    = axi.awvalid && axi.awready;
  assign w_w_hs     = axi.wvalid && axi.wready;
  assign w_aw_match = (axi.awaddr[31:0] == CON_ADDR) && (axi.awlen == 4'd0);
  assign w_snoop    = w_w_hs && (r_pending || (w_aw_hs && w_aw_match));

  always_ff @(posedge clk) begin
    if (rst)                        r_pending <= 1'b0;
    else if (w_w_hs && axi.wlast)   r_pending <= 1'b0;
    else if (w_aw_hs)               r_pending <= w_aw_match;
  end

  always_comb begin : extract
    int n_lane, n_bit, lane_idx, bit_idx;
    n_lane    = 0;
    n_bit     = 0;
    lane_idx  = 0;
    bit_idx   = 0;
    w_chr_vld = 1'b0;
    w_chr     = 8'h00;
    for (int l = 0; l < NLANE; l++) begin
      if (|axi.wstrb[l*4 +: 4]) begin
        n_lane++;
        lane_idx = l;
      end
    end
    for (int b = 0; b < NBYTE; b++) begin
      if (axi.wstrb[b]) begin
        n_bit++;
        bit_idx = b;
      end
    end
    if (n_lane == 1 && axi.wstrb[lane_idx*4 +: 4] == 4'hF) begin
      w_chr_vld = 1'b1;
      w_chr     = axi.wdata[lane_idx*32 +: 8];
    end else if (n_bit == 1) begin
      w_chr_vld = 1'b1;
      w_chr     = axi.wdata[bit_idx*8 +: 8];
    end
  end

  assign w_push = w_snoop && w_chr_vld && (r_state == S_RUN);

  // ---------------- console FIFO ----------------
  logic [7:0]   r_mem [CON_DEPTH];
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  logic         w_empty, w_full, w_pop, w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && con_rdy;
  assign w_wr    = w_push && (!w_full || w_pop);

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_chr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      con_ovf  <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_wr) con_ovf <= 1'b1;
    end
  end

  assign con_vld  = !w_empty;
  assign con_char = w_empty ? 8'h00 : r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_tb_run_monitor.sv
// Randomised and directed bench for tb_run_monitor, checked every cycle
// against a queue/arithmetic reference model of the run monitor rules.
module tb_tb_run_monitor;
  localparam int          NR    = 2;
  localparam int          NW    = 2;
  localparam int          WB_W  = 64;
  localparam int          AW    = 40;
  localparam int          DW    = 128;
  localparam int          CHK   = 16;
  localparam int          CNT_W = 32;
  localparam int          DEPTH = 8;
  localparam logic [63:0] PASS_V = 64'h444333222;
  localparam logic [63:0] FAIL_V = 64'h2382348720;
  localparam logic [31:0] CON_A  = 32'h90000000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        retire_vld;
  logic [NW-1:0]        wb_vld;
  logic [NW*WB_W-1:0]   wb_data;
  logic                 con_rdy;
  logic                 con_vld, con_ovf, done, st_pass, st_fail, st_timeout;
  logic [7:0]           con_char;
  logic [CNT_W-1:0]     cyc_cnt;
  logic [63:0]          retire_total;

  tb_run_monitor_if #(.AXI_AW(AW), .AXI_DW(DW)) axi ();

  tb_run_monitor #(
    .NUM_RETIRE(NR), .NUM_WB(NW), .WB_W(WB_W), .AXI_AW(AW), .AXI_DW(DW),
    .CHK_CYC(CHK), .CNT_W(CNT_W), .PASS_VAL(PASS_V), .FAIL_VAL(FAIL_V),
    .CON_ADDR(CON_A), .CON_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .retire_vld(retire_vld), .wb_vld(wb_vld),
    .wb_data(wb_data), .axi(axi), .con_rdy(con_rdy), .con_vld(con_vld),
    .con_char(con_char), .con_ovf(con_ovf), .done(done), .st_pass(st_pass),
    .st_fail(st_fail), .st_timeout(st_timeout), .cyc_cnt(cyc_cnt),
    .retire_total(retire_total)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 running, 1 pass, 2 fail, 3 timeout
  int          m_state;
  logic [31:0] m_cyc;
  logic [63:0] m_ret;
  int          m_win_rets;
  logic        m_pending, m_ovf;
  logic [7:0]  m_q[$];

  function automatic int extract(input logic [DW/8-1:0] s, input logic [DW-1:0] d);
    int idx[$];
    for (int b = 0; b < DW/8; b++) if (s[b]) idx.push_back(b);
    if (idx.size() == 4 && idx[0] % 4 == 0 && idx[3] == idx[0] + 3) return int'(d[idx[0]*8 +: 8]);
    if (idx.size() == 1) return int'(d[idx[0]*8 +: 8]);
    return -1;
  endfunction

  task automatic model_step();
    bit fail_hit, pass_hit, aw_hs, w_hs, aw_match, take, last_cyc;
    int nret, ch, nxt;
    if (rst) begin
      m_state = 0; m_cyc = 0; m_ret = 0; m_win_rets = 0;
      m_pending = 0; m_ovf = 0; m_q.delete();
      return;
    end
    nret = $countones(retire_vld);
    fail_hit = 0;
    pass_hit = 0;
    for (int k = 0; k < NW; k++) begin
      if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == FAIL_V) fail_hit = 1;
      if (wb_vld[k] && wb_data[k*WB_W +: WB_W] == PASS_V) pass_hit = 1;
    end
    aw_hs    = axi.awvalid && axi.awready;
    w_hs     = axi.wvalid && axi.wready;
    aw_match = (axi.awaddr[31:0] == CON_A) && (axi.awlen == 0);
    ch       = extract(axi.wstrb, axi.wdata);
    take     = w_hs && (m_pending || (aw_hs && aw_match)) && ch >= 0 && m_state == 0;
    if (m_q.size() > 0 && con_rdy) void'(m_q.pop_front());
    if (take) begin
      if (m_q.size() < DEPTH) m_q.push_back(8'(ch));
      else m_ovf = 1;
    end
    if (aw_hs) m_pending = aw_match;
    if (w_hs && axi.wlast) m_pending = 0;
    if (m_state == 0) begin
      last_cyc = (m_cyc % CHK) == CHK - 1;
      nxt = fail_hit ? 2 : pass_hit ? 1 : (last_cyc && m_win_rets + nret == 0) ? 3 : 0;
      if (nxt == 0) begin
        m_cyc++;
        m_ret += 64'(nret);
        m_win_rets = last_cyc ? 0 : m_win_rets + nret;
      end
      m_state = nxt;
    end
  endtask

  task automatic compare_all();
    check("done",       done,         64'(m_state != 0));
    check("st_pass",    st_pass,      64'(m_state == 1));
    check("st_fail",    st_fail,      64'(m_state == 2));
    check("st_timeout", st_timeout,   64'(m_state == 3));
    check("cyc_cnt",    cyc_cnt,      64'(m_cyc));
    check("retire_tot", retire_total, m_ret);
    check("con_vld",    con_vld,      64'(m_q.size() > 0));
    check("con_char",   con_char,     64'(m_q.size() > 0 ? m_q[0] : 8'h00));
    check("con_ovf",    con_ovf,      64'(m_ovf));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    retire_vld  = '0;
    wb_vld      = '0;
    wb_data     = '0;
    axi.awvalid = 0; axi.awready = 0; axi.awaddr = '0; axi.awlen = '0;
    axi.wvalid  = 0; axi.wready  = 0; axi.wlast  = 0;
    axi.wstrb   = '0; axi.wdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  // AW handshake in one cycle, single W beat with wlast in the next.
  task automatic axi_wr(input logic [31:0] addr, input logic [3:0] len,
                        input logic [15:0] strb, input logic [DW-1:0] data);
    axi.awvalid = 1; axi.awready = 1; axi.awaddr = {8'h00, addr}; axi.awlen = len;
    step();
    axi.awvalid = 0; axi.awready = 0;
    axi.wvalid = 1; axi.wready = 1; axi.wlast = 1; axi.wstrb = strb; axi.wdata = data;
    step();
    axi.wvalid = 0; axi.wready = 0; axi.wlast = 0; axi.wstrb = '0;
  endtask

  // AW and W handshakes in the same cycle.
  task automatic axi_wr1(input logic [15:0] strb, input logic [DW-1:0] data);
    axi.awvalid = 1; axi.awready = 1; axi.awaddr = {8'h00, CON_A}; axi.awlen = 0;
    axi.wvalid = 1; axi.wready = 1; axi.wlast = 1; axi.wstrb = strb; axi.wdata = data;
    step();
    axi.awvalid = 0; axi.awready = 0; axi.wvalid = 0; axi.wready = 0;
    axi.wlast = 0; axi.wstrb = '0;
  endtask

  initial begin
    logic [DW-1:0] d;
    int since_done;
    rst = 1;
    con_rdy = 0;
    idle_inputs();

    // Reset values
    do_reset();
    check("rst_done", done, 64'd0);
    check("rst_cyc", cyc_cnt, 64'd0);

    // Pass after steady retires (spacing keeps every 16-cycle window busy)
    for (int i = 0; i < 20; i++) begin
      retire_vld = 2'b01;
      step();
      retire_vld = '0;
      for (int j = 0; j < 9; j++) step();
    end
    wb_vld = 2'b10;
    wb_data = {PASS_V, 64'h0};
    step();
    idle_inputs();
    check("pass_st", st_pass, 64'd1);
    check("pass_fail", st_fail, 64'd0);
    check("pass_ret", retire_total, 64'd20);
    step();
    check("pass_sticky", st_pass, 64'd1);

    // FAIL wins over PASS in the same cycle
    do_reset();
    wb_vld = 2'b11;
    wb_data = {FAIL_V, PASS_V};
    step();
    idle_inputs();
    check("prio_fail", st_fail, 64'd1);
    check("prio_pass", st_pass, 64'd0);

    // Timeout with no retires at all
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("to_early", done, 64'd0);
    step();
    check("to_fire", st_timeout, 64'd1);

    // Retire in the last window cycle saves that window only
    do_reset();
    for (int i = 0; i < 15; i++) step();
    retire_vld = 2'b10;
    step();
    retire_vld = '0;
    check("to_saved", done, 64'd0);
    for (int i = 0; i < 15; i++) step();
    check("to_win2_early", done, 64'd0);
    step();
    check("to_win2", st_timeout, 64'd1);

    // Console captures (retires held high so the watchdog stays quiet)
    do_reset();
    retire_vld = 2'b01;
    d = '0; d[71:64] = 8'h41;
    axi_wr(CON_A, 4'd0, 16'h0F00, d);
    check("con_lane_vld", con_vld, 64'd1);
    check("con_lane_chr", con_char, 64'h41);
    do_reset();
    retire_vld = 2'b01;
    axi_wr(CON_A, 4'd0, 16'h00FF, d);
    check("con_2lane", con_vld, 64'd0);

    do_reset();
    retire_vld = 2'b01;
    d = '0; d[7:0] = 8'h0A;
    axi_wr(32'h80000000, 4'd0, 16'h0001, d);
    check("con_badaddr", con_vld, 64'd0);
    axi.wvalid = 1; axi.wready = 1; axi.wlast = 1; axi.wstrb = 16'h0001; axi.wdata = d;
    step();
    axi.wvalid = 0; axi.wready = 0; axi.wlast = 0; axi.wstrb = '0;
    check("con_nopend", con_vld, 64'd0);
    axi_wr(CON_A, 4'd0, 16'h0001, d);
    check("con_byte", con_char, 64'h0A);
    axi_wr(CON_A, 4'd3, 16'h0001, d);
    check("con_burst", con_vld, 64'd1);

    // Overflow, then push/pop at full and drain
    do_reset();
    retire_vld = 2'b01;
    con_rdy = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = '0; d[7:0] = 8'(8'h30 + i);
      axi_wr1(16'h0001, d);
    end
    check("ovf_flag", con_ovf, 64'd1);
    check("ovf_head", con_char, 64'h30);
    con_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      d = '0; d[39:32] = 8'(8'h60 + i);
      axi_wr1(16'h00F0, d);
    end
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("drain_empty", con_vld, 64'd0);
    retire_vld = '0;

    // Randomised traffic with occasional resets
    do_reset();
    since_done = 0;
    for (int c = 0; c < 3000; c++) begin
      since_done = (m_state != 0) ? since_done + 1 : 0;
      rst = ($urandom_range(0, 299) == 0) || (since_done > 6);
      retire_vld = ($urandom_range(0, 11) == 0) ? NR'($urandom) : '0;
      wb_vld = NW'($urandom);
      for (int k = 0; k < NW; k++) begin
        int r;
        r = $urandom_range(0, 399);
        wb_data[k*WB_W +: WB_W] = (r == 0) ? FAIL_V : (r < 3) ? PASS_V : {$urandom, $urandom};
      end
      axi.awvalid = 1'($urandom);
      axi.awready = 1'($urandom);
      axi.awaddr  = {8'($urandom), ($urandom_range(0, 1) == 0) ? CON_A : 32'($urandom)};
      axi.awlen   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      axi.wvalid  = 1'($urandom);
      axi.wready  = 1'($urandom);
      axi.wlast   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: axi.wstrb = 16'h0001 << $urandom_range(0, 15);
        1: axi.wstrb = 16'h000F << (4 * $urandom_range(0, 3));
        2: axi.wstrb = 16'h00F0 | (16'h0001 << $urandom_range(0, 15));
        default: axi.wstrb = 16'($urandom);
      endcase
      axi.wdata = {$urandom, $urandom, $urandom, $urandom};
      con_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
